// File: rtl/cnt4_seq_pkg.sv
// Shared types and constants for the cnt4 interval sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnt4_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HOLD,
        ST_FIN
    } seq_state_e;

    localparam logic [3:0] CNT_MAX = 4'hF;
    localparam logic [3:0] CNT_MIN = 4'h0;

    // Up-counting starts PERIOD steps below CNT_MAX; down-counting starts at PERIOD.
    function automatic logic [3:0] load_value(input logic dir, input logic [3:0] period);
        return dir ? period : ~period;
    endfunction

endpackage

// File: rtl/counter_4b.sv
// 4-bit loadable up/down counter with combinational terminal-count flag.
// Latency: load/count visible one cycle after LD/CE; CO is combinational from Q.
// Backpressure: none; CE=0 simply holds the value.
module counter_4b
    import cnt4_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m,
    input  logic       ld,
    input  logic       ce,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       co
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CNT_MIN;
        end else if (ld) begin
            q <= d;
        end else if (ce) begin
            q <= m ? q - 4'd1 : q + 4'd1;
        end
    end

    assign co = m ? (q == CNT_MIN) : (q == CNT_MAX);

endmodule

// File: rtl/cnt4_seq_ctrl.sv
// Repeatable interval timer driving counter_4b; CNT4_SEQ_PAUSE_EN enables PAUSE/HOLD.
// Latency: START to DONE = 2 + (NPER+1)(PERIOD+1) cycles with continuous TICK.
// Backpressure: TICK is a strobe; ticks during LOAD, HOLD or FIN are dropped.
module cnt4_seq_ctrl
    import cnt4_seq_pkg::*;
#(
    parameter int NPER_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic              PAUSE,
    input  logic              TICK,
    input  logic              DIR,
    input  logic [3:0]        PERIOD,
    input  logic [NPER_W-1:0] NPER,
    output logic              BUSY,
    output logic              PER_EV,
    output logic              DONE,
    output logic [NPER_W-1:0] REMAIN,
    output logic [3:0]        CNT_Q
);

    seq_state_e state;
    logic       cnt_m;
    logic [3:0] cnt_d;
    logic       cnt_ld;
    logic       cnt_ce;
    logic       cnt_co;
    logic       pause_act;
    logic       run_ok;
    logic       term_tick;
    logic       last_per;

`ifdef CNT4_SEQ_PAUSE_EN
    assign pause_act = PAUSE;
`else
    assign pause_act = PAUSE & 1'b0;
`endif

    assign run_ok    = (state == ST_RUN) && !pause_act;
    assign term_tick = run_ok && TICK && cnt_co;
    assign last_per  = (REMAIN == '0);
    assign PER_EV    = term_tick;

    // STOP freezes the datapath so the aborted count stays visible on CNT_Q.
    assign cnt_ld = !STOP && ((state == ST_LOAD) || (term_tick && !last_per));
    assign cnt_ce = !STOP && run_ok && TICK && !(term_tick && last_per);

    counter_4b u_cnt (
        .clk   (CLK),
        .rst_n (~RST),
        .m     (cnt_m),
        .ld    (cnt_ld),
        .ce    (cnt_ce),
        .d     (cnt_d),
        .q     (CNT_Q),
        .co    (cnt_co)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            REMAIN <= '0;
            cnt_m  <= 1'b0;
            cnt_d  <= CNT_MIN;
        end else begin
            DONE <= 1'b0;
            if (STOP && state != ST_IDLE) begin
                state  <= ST_IDLE;
                BUSY   <= 1'b0;
                REMAIN <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (START && !STOP) begin
                            cnt_m  <= DIR;
                            cnt_d  <= load_value(DIR, PERIOD);
                            REMAIN <= NPER;
                            BUSY   <= 1'b1;
                            state  <= ST_LOAD;
                        end
                    end
                    ST_LOAD: state <= ST_RUN;
                    ST_RUN: begin
`ifdef CNT4_SEQ_PAUSE_EN
                        if (pause_act) state <= ST_HOLD;
                        else
`endif
                        if (term_tick) begin
                            if (!last_per) begin
                                REMAIN <= REMAIN - NPER_W'(1);
                            end else begin
                                state <= ST_FIN;
                                DONE  <= 1'b1;
                            end
                        end
                    end
`ifdef CNT4_SEQ_PAUSE_EN
                    ST_HOLD: if (!PAUSE) state <= ST_RUN;
`endif
                    ST_FIN: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnt4_seq_ctrl.sv
// Self-checking bench for cnt4_seq_ctrl: vector table, directed corner sequences
// and random stimulus against a tick-counting reference model.
module tb_cnt4_seq_ctrl;

    localparam int NPER_W = 8;
`ifdef CNT4_SEQ_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HOLD = 3, P_FIN = 4;

    logic              CLK = 1'b0;
    logic              RST, START, STOP, PAUSE, TICK, DIR;
    logic [3:0]        PERIOD;
    logic [NPER_W-1:0] NPER;
    logic              BUSY, PER_EV, DONE;
    logic [NPER_W-1:0] REMAIN;
    logic [3:0]        CNT_Q;

    cnt4_seq_ctrl #(.NPER_W(NPER_W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .PAUSE(PAUSE),
        .TICK(TICK), .DIR(DIR), .PERIOD(PERIOD), .NPER(NPER),
        .BUSY(BUSY), .PER_EV(PER_EV), .DONE(DONE), .REMAIN(REMAIN), .CNT_Q(CNT_Q)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which phase we are in, how many ticks of the current
    // period have been consumed, and the counter value that implies.
    int m_phase, m_q, m_k, m_rem, m_dir, m_per, m_busy, m_done;
    int ev_cnt, done_cnt, done_idx;
    int ev_idx[$];

    typedef struct {
        int start, tick, dir, period, nper;
        int busy, pev, done, rem, q;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_q = 0; m_k = 0; m_rem = 0;
        m_dir = 0; m_per = 0; m_busy = 0; m_done = 0;
    endtask

    function automatic int start_value();
        return (m_dir != 0) ? m_per : 15 - m_per;
    endfunction

    function automatic int model_pev();
        bit paused;
        paused = PAUSE_EN && PAUSE;
        return (m_phase == P_RUN && !paused && TICK && m_k == m_per) ? 1 : 0;
    endfunction

    task automatic model_edge();
        bit paused;
        paused = PAUSE_EN && PAUSE;
        if (STOP && m_phase != P_IDLE) begin
            m_phase = P_IDLE; m_rem = 0; m_busy = 0; m_done = 0;
        end else begin
            m_done = 0;
            case (m_phase)
                P_IDLE: if (START && !STOP) begin
                    m_dir = int'(DIR); m_per = int'(PERIOD); m_rem = int'(NPER);
                    m_busy = 1; m_phase = P_LOAD;
                end
                P_LOAD: begin
                    m_q = start_value(); m_k = 0; m_phase = P_RUN;
                end
                P_RUN: if (paused) begin
                    m_phase = P_HOLD;
                end else if (TICK) begin
                    if (m_k == m_per) begin
                        if (m_rem > 0) begin
                            m_rem--; m_k = 0; m_q = start_value();
                        end else begin
                            m_phase = P_FIN; m_done = 1;
                        end
                    end else begin
                        m_k++;
                        m_q = (m_dir != 0) ? m_q - 1 : m_q + 1;
                    end
                end
                P_HOLD: if (!PAUSE) m_phase = P_RUN;
                P_FIN: begin
                    m_phase = P_IDLE; m_busy = 0;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    // Inputs are already set (posedge+1); compare at negedge, then advance.
    task automatic step(input int idx, input int ti);
        @(negedge CLK);
        check("busy",   int'(BUSY),   m_busy);
        check("per_ev", int'(PER_EV), model_pev());
        check("done",   int'(DONE),   m_done);
        check("remain", int'(REMAIN), m_rem);
        check("cnt_q",  int'(CNT_Q),  m_q);
        if (ti >= 0) begin
            check("tbl_busy",   int'(BUSY),   tbl[ti].busy);
            check("tbl_per_ev", int'(PER_EV), tbl[ti].pev);
            check("tbl_done",   int'(DONE),   tbl[ti].done);
            check("tbl_remain", int'(REMAIN), tbl[ti].rem);
            check("tbl_cnt_q",  int'(CNT_Q),  tbl[ti].q);
        end
        if (PER_EV) begin ev_cnt++; ev_idx.push_back(idx); end
        if (DONE) begin done_cnt++; done_idx = idx; end
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic clear_counts();
        ev_cnt = 0; done_cnt = 0; done_idx = -1; ev_idx.delete();
    endtask

    task automatic do_seq(input bit dir, input int per, input int nper,
                          input int tick_mode, input int p_from, input int p_len);
        int idx;
        idx = 0;
        clear_counts();
        START = 1'b1; STOP = 1'b0; DIR = dir; PERIOD = 4'(per); NPER = NPER_W'(nper);
        do begin
            TICK  = (tick_mode == 0) ? 1'b1 : (idx % 2 == 0);
            PAUSE = (idx >= p_from && idx < p_from + p_len);
            step(idx, -1);
            START = 1'b0;
            idx++;
        end while (m_phase != P_IDLE && idx < 600);
        PAUSE = 1'b0;
        if (idx >= 600) begin
            n_tests++; n_fail++;
            $display("FAIL seq_timeout: still busy after %0d cycles, expected idle", idx);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            start tick dir per nper | busy pev done rem q
        tbl[0]  = '{1, 1, 0, 3, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 3, 0,  1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 3, 0,  1, 0, 0, 0, 12};
        tbl[3]  = '{0, 1, 0, 3, 0,  1, 0, 0, 0, 13};
        tbl[4]  = '{0, 1, 0, 3, 0,  1, 0, 0, 0, 14};
        tbl[5]  = '{0, 1, 0, 3, 0,  1, 1, 0, 0, 15};
        tbl[6]  = '{0, 1, 0, 3, 0,  1, 0, 1, 0, 15};
        tbl[7]  = '{0, 1, 0, 3, 0,  0, 0, 0, 0, 15};
        tbl[8]  = '{1, 1, 1, 0, 3,  0, 0, 0, 0, 15};
        tbl[9]  = '{0, 1, 1, 0, 3,  1, 0, 0, 3, 15};
        tbl[10] = '{0, 1, 1, 0, 3,  1, 1, 0, 3, 0};
        tbl[11] = '{0, 1, 1, 0, 3,  1, 1, 0, 2, 0};
        tbl[12] = '{0, 1, 1, 0, 3,  1, 1, 0, 1, 0};
        tbl[13] = '{0, 1, 1, 0, 3,  1, 1, 0, 0, 0};
        tbl[14] = '{0, 1, 1, 0, 3,  1, 0, 1, 0, 0};
        tbl[15] = '{0, 1, 1, 0, 3,  0, 0, 0, 0, 0};

        RST = 1'b1; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0; TICK = 1'b0;
        DIR = 1'b0; PERIOD = 4'd0; NPER = '0;
        model_reset();
        clear_counts();
        #12;
        check("rst_busy",   int'(BUSY),   0);
        check("rst_per_ev", int'(PER_EV), 0);
        check("rst_done",   int'(DONE),   0);
        check("rst_remain", int'(REMAIN), 0);
        check("rst_cnt_q",  int'(CNT_Q),  0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Vector table: up single period, then PERIOD=0 down repeats.
        for (int i = 0; i < 16; i++) begin
            START  = (tbl[i].start != 0);
            TICK   = (tbl[i].tick != 0);
            DIR    = (tbl[i].dir != 0);
            PERIOD = 4'(tbl[i].period);
            NPER   = NPER_W'(tbl[i].nper);
            step(i, i);
        end

        // Down, three periods, TICK every other cycle.
        do_seq(1'b1, 2, 2, 1, 1000, 0);
        check("down_ev_count", ev_cnt, 3);
        check("down_done_count", done_cnt, 1);
        for (int i = 1; i < ev_idx.size(); i++)
            check("down_ev_spacing", ev_idx[i] - ev_idx[i-1], 6);

        // START-to-DONE latency with continuous TICK.
        do_seq(1'b0, 3, 0, 0, 1000, 0);
        check("lat_up_single", done_idx, 6);
        do_seq(1'b1, 5, 2, 0, 1000, 0);
        check("lat_down_rep", done_idx, 20);
        check("lat_down_ev_count", ev_cnt, 3);

        // PAUSE held for 5 cycles while Q=13.
        do_seq(1'b0, 3, 0, 0, 3, 5);
        check("pause_ev_count", ev_cnt, 1);
        check("pause_done_count", done_cnt, 1);
`ifndef CNT4_SEQ_PAUSE_EN
        check("pause_ignored_ev_idx", ev_idx[0], 5);
        check("pause_ignored_done_idx", done_idx, 6);
`endif

        // START while busy is ignored; STOP at REMAIN=1 aborts without DONE.
        begin
            int idx;
            clear_counts();
            START = 1'b1; DIR = 1'b0; PERIOD = 4'd1; NPER = NPER_W'(2); TICK = 1'b1;
            for (idx = 0; idx < 40; idx++) begin
                if (m_phase == P_RUN && m_rem == 1) break;
                step(idx, -1);
                START = (idx >= 0 && idx < 3);
                if (START) begin DIR = 1'b1; PERIOD = 4'd5; NPER = NPER_W'(7); end
            end
            START = 1'b0;
            if (idx >= 40) begin
                n_tests++; n_fail++;
                $display("FAIL stop_setup_timeout: REMAIN never reached 1 within %0d cycles", idx);
            end
            check("stop_pre_remain", int'(REMAIN), 1);
            STOP = 1'b1;
            step(100, -1);
            STOP = 1'b0;
            for (int i = 0; i < 3; i++) step(101 + i, -1);
            check("stop_done_count", done_cnt, 0);
            check("stop_busy_after", int'(BUSY), 0);
        end

        // Asynchronous reset in the middle of a run, then a normal restart.
        START = 1'b1; DIR = 1'b0; PERIOD = 4'd7; NPER = NPER_W'(5); TICK = 1'b1;
        step(0, -1);
        START = 1'b0;
        for (int i = 1; i < 6; i++) step(i, -1);
        #2 RST = 1'b1;
        #1;
        check("arst_busy",   int'(BUSY),   0);
        check("arst_per_ev", int'(PER_EV), 0);
        check("arst_done",   int'(DONE),   0);
        check("arst_remain", int'(REMAIN), 0);
        check("arst_cnt_q",  int'(CNT_Q),  0);
        RST = 1'b0;
        model_reset();
        do_seq(1'b0, 2, 1, 0, 1000, 0);
        check("arst_restart_done", done_cnt, 1);
        check("arst_restart_lat", done_idx, 8);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            START  = ($urandom % 8) == 0;
            STOP   = ($urandom % 50) == 0;
            TICK   = ($urandom % 10) < 7;
            PAUSE  = ($urandom % 10) == 0;
            DIR    = 1'($urandom % 2);
            PERIOD = (($urandom % 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            NPER   = (($urandom % 16) == 0) ? NPER_W'(255) : NPER_W'($urandom_range(0, 3));
            step(i, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
